// File: rtl/sc_statemachine_autorepeat.sv
// Command FSM for the register shifter, with auto-repeat on held shift requests.
// Converts active-low clear/load buttons and a 2-bit shift selector into
// one-cycle command pulses. A held shift re-issues pulses after REPEAT_DELAY
// cycles, then every REPEAT_PERIOD cycles. Also reports the pulse count of
// the current or most recent hold.
//
// Ports
//   SC_STATEMACHINE_CLOCK_50            in   system clock, rising edge
//   SC_STATEMACHINE_RESET_InHigh        in   async reset, active high
//   SC_STATEMACHINE_clear_InLow         in   clear request, active low
//   SC_STATEMACHINE_load_InLow          in   load request, active low
//   SC_STATEMACHINE_shiftselection_In   in   01=right, 10=left, 00/11=idle
//   SC_STATEMACHINE_clear_OutLow        out  clear pulse, active low
//   SC_STATEMACHINE_load_OutLow         out  load pulse, active low
//   SC_STATEMACHINE_shiftselection_Out  out  01/10 one-cycle shift, 11=hold
//   SC_STATEMACHINE_shiftcount_Out      out  shift pulses in current/last hold
//   SC_STATEMACHINE_repeating_Out       out  high during auto-repeat phase
//
// state    | meaning
// S_RESET  | just out of reset, outputs idle
// S_START  | one settling cycle before sampling requests
// S_CHECK  | sample requests by priority clear > load > right > left
// S_CLR_P  | clear pulse, count cleared
// S_CLR_W  | wait for clear release
// S_LD_P   | load pulse
// S_LD_W   | wait for load release
// S_SH_P   | first shift pulse of a hold, count=1, timer=delay
// S_SH_W   | holding, before first repeat
// S_RP_P   | repeat shift pulse, timer=period
// S_RP_W   | holding, in repeat phase
module sc_statemachine_autorepeat #(
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000,
   parameter int TMR_W         = 26,
   parameter int CNT_W         = 8
) (
   input  logic             SC_STATEMACHINE_CLOCK_50,
   input  logic             SC_STATEMACHINE_RESET_InHigh,
   input  logic             SC_STATEMACHINE_clear_InLow,
   input  logic             SC_STATEMACHINE_load_InLow,
   input  logic [1:0]       SC_STATEMACHINE_shiftselection_In,
   output logic             SC_STATEMACHINE_clear_OutLow,
   output logic             SC_STATEMACHINE_load_OutLow,
   output logic [1:0]       SC_STATEMACHINE_shiftselection_Out,
   output logic [CNT_W-1:0] SC_STATEMACHINE_shiftcount_Out,
   output logic             SC_STATEMACHINE_repeating_Out
);

   typedef enum logic [3:0] {
      S_RESET = 4'd0,
      S_START = 4'd1,
      S_CHECK = 4'd2,
      S_CLR_P = 4'd3,
      S_CLR_W = 4'd4,
      S_LD_P  = 4'd5,
      S_LD_W  = 4'd6,
      S_SH_P  = 4'd7,
      S_SH_W  = 4'd8,
      S_RP_P  = 4'd9,
      S_RP_W  = 4'd10
   } state_t;

   // Timer counts down from N-1 starting in the pulse cycle, so the terminal
   // count lands on the cycle before the next pulse is due.
   localparam logic [TMR_W-1:0] DLY_LD = TMR_W'(REPEAT_DELAY - 1);
   localparam logic [TMR_W-1:0] PER_LD = TMR_W'(REPEAT_PERIOD - 1);

   state_t           state, state_nx;
   logic [TMR_W-1:0] timer, timer_nx;
   logic [CNT_W-1:0] count, count_nx;
   logic [1:0]       dir, dir_nx;

   logic clr_req, ld_req, sel_held, tmr_tc;

   assign clr_req  = ~SC_STATEMACHINE_clear_InLow;
   assign ld_req   = ~SC_STATEMACHINE_load_InLow;
   assign sel_held = (SC_STATEMACHINE_shiftselection_In == dir);
   assign tmr_tc   = (timer == '0);

   always_ff @(posedge SC_STATEMACHINE_CLOCK_50 or posedge SC_STATEMACHINE_RESET_InHigh) begin
      if (SC_STATEMACHINE_RESET_InHigh) begin
         state <= S_RESET;
         timer <= '0;
         count <= '0;
         dir   <= '0;
      end else begin
         state <= state_nx;
         timer <= timer_nx;
         count <= count_nx;
         dir   <= dir_nx;
      end
   end

   always_comb begin
      state_nx = S_CHECK;
      case (state)
         S_RESET: state_nx = S_START;
         S_START: state_nx = S_CHECK;
         S_CHECK: begin
            if (clr_req)
               state_nx = S_CLR_P;
            else if (ld_req)
               state_nx = S_LD_P;
            else if (SC_STATEMACHINE_shiftselection_In == 2'b01 ||
                     SC_STATEMACHINE_shiftselection_In == 2'b10)
               state_nx = S_SH_P;
            else
               state_nx = S_CHECK;
         end
         S_CLR_P: state_nx = S_CLR_W;
         S_CLR_W: state_nx = clr_req ? S_CLR_W : S_CHECK;
         S_LD_P:  state_nx = S_LD_W;
         S_LD_W:  state_nx = ld_req ? S_LD_W : S_CHECK;
         S_SH_P:  state_nx = S_SH_W;
         S_RP_P:  state_nx = S_RP_W;
         // Release/direction change wins over a timer expiring the same cycle.
         S_SH_W: begin
            if (!sel_held)   state_nx = S_CHECK;
            else if (tmr_tc) state_nx = S_RP_P;
            else             state_nx = S_SH_W;
         end
         S_RP_W: begin
            if (!sel_held)   state_nx = S_CHECK;
            else if (tmr_tc) state_nx = S_RP_P;
            else             state_nx = S_RP_W;
         end
         default: state_nx = S_CHECK;
      endcase
   end

   always_comb begin
      timer_nx = tmr_tc ? timer : timer - 1'b1;
      count_nx = count;
      dir_nx   = dir;
      case (state_nx)
         S_CLR_P: count_nx = '0;
         S_SH_P: begin
            timer_nx = DLY_LD;
            count_nx = CNT_W'(1);
            dir_nx   = SC_STATEMACHINE_shiftselection_In;
         end
         S_RP_P: begin
            timer_nx = PER_LD;
            count_nx = (&count) ? count : count + 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      SC_STATEMACHINE_clear_OutLow       = 1'b1;
      SC_STATEMACHINE_load_OutLow        = 1'b1;
      SC_STATEMACHINE_shiftselection_Out = 2'b11;
      SC_STATEMACHINE_repeating_Out      = 1'b0;
      case (state)
         S_CLR_P: SC_STATEMACHINE_clear_OutLow = 1'b0;
         S_LD_P:  SC_STATEMACHINE_load_OutLow  = 1'b0;
         S_SH_P:  SC_STATEMACHINE_shiftselection_Out = dir;
         S_RP_P: begin
            SC_STATEMACHINE_shiftselection_Out = dir;
            SC_STATEMACHINE_repeating_Out      = 1'b1;
         end
         S_RP_W:  SC_STATEMACHINE_repeating_Out = 1'b1;
         default: ;
      endcase
   end

   assign SC_STATEMACHINE_shiftcount_Out = count;

endmodule

// File: tb/tb_sc_statemachine_autorepeat.sv
// Bench for sc_statemachine_autorepeat with short repeat timing.
// A behavioural model (hold age and arithmetic pulse schedule) is compared
// against the DUT every cycle; directed scenarios add literal expectations.
module tb_sc_statemachine_autorepeat;

   localparam int D    = 4;
   localparam int P    = 2;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clr_in = 1'b1;
   logic          ld_in = 1'b1;
   logic [1:0]    sel_in = 2'b00;
   logic          clr_out, ld_out, rep_out;
   logic [1:0]    sel_out;
   logic [CW-1:0] cnt_out;

   sc_statemachine_autorepeat #(
      .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .TMR_W(4), .CNT_W(CW)
   ) dut (
      .SC_STATEMACHINE_CLOCK_50           (clk),
      .SC_STATEMACHINE_RESET_InHigh       (rst),
      .SC_STATEMACHINE_clear_InLow        (clr_in),
      .SC_STATEMACHINE_load_InLow         (ld_in),
      .SC_STATEMACHINE_shiftselection_In  (sel_in),
      .SC_STATEMACHINE_clear_OutLow       (clr_out),
      .SC_STATEMACHINE_load_OutLow        (ld_out),
      .SC_STATEMACHINE_shiftselection_Out (sel_out),
      .SC_STATEMACHINE_shiftcount_Out     (cnt_out),
      .SC_STATEMACHINE_repeating_Out      (rep_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Event logs filled by the compare process, inspected by directed tests.
   int         shift_q[$];
   logic [1:0] shdir_q[$];
   int         clr_q[$];
   int         ld_q[$];
   int         rep_first;

   // Model: what the controller is doing, and for how many cycles.
   typedef enum {K_BOOT, K_AVAIL, K_CLR, K_LOAD, K_SHIFT} kind_t;
   kind_t      m_kind = K_BOOT;
   int         m_age  = 0;
   int         m_cnt  = 0;
   logic [1:0] m_dir  = 2'b00;

   function automatic bit is_pulse(input int t);
      return (t == 0) || (t >= D && ((t - D) % P) == 0);
   endfunction

   always @(negedge clk) begin
      bit         pulse;
      logic       e_clr, e_ld, e_rep;
      logic [1:0] e_sel;
      pulse = 1'b0;
      e_clr = 1'b1; e_ld = 1'b1; e_sel = 2'b11; e_rep = 1'b0;
      if (rst) begin
         m_kind = K_BOOT; m_age = 0; m_cnt = 0;
      end else begin
         case (m_kind)
            K_CLR:  if (m_age == 0) begin e_clr = 1'b0; m_cnt = 0; end
            K_LOAD: if (m_age == 0) e_ld = 1'b0;
            K_SHIFT: begin
               pulse = is_pulse(m_age);
               if (pulse) begin
                  e_sel = m_dir;
                  m_cnt = (m_age == 0) ? 1 : ((m_cnt == CMAX) ? CMAX : m_cnt + 1);
               end
               e_rep = (m_age >= D);
            end
            default: ;
         endcase
      end
      chk("clear_out", clr_out, e_clr);
      chk("load_out",  ld_out,  e_ld);
      chk("sel_out",   sel_out, e_sel);
      chk("count",     cnt_out, m_cnt);
      chk("repeating", rep_out, e_rep);

      if (sel_out == 2'b01 || sel_out == 2'b10) begin
         shift_q.push_back(cyc);
         shdir_q.push_back(sel_out);
      end
      if (!clr_out) clr_q.push_back(cyc);
      if (!ld_out)  ld_q.push_back(cyc);
      if (rep_out && rep_first < 0) rep_first = cyc;

      if (!rst) begin
         case (m_kind)
            K_BOOT: if (m_age >= 1) m_kind = K_AVAIL; else m_age++;
            K_AVAIL: begin
               m_age = 0;
               if (!clr_in)     m_kind = K_CLR;
               else if (!ld_in) m_kind = K_LOAD;
               else if (sel_in == 2'b01 || sel_in == 2'b10) begin
                  m_kind = K_SHIFT; m_dir = sel_in;
               end
            end
            K_CLR:   if (m_age >= 1 && clr_in) m_kind = K_AVAIL; else m_age++;
            K_LOAD:  if (m_age >= 1 && ld_in)  m_kind = K_AVAIL; else m_age++;
            K_SHIFT: if (!pulse && sel_in != m_dir) m_kind = K_AVAIL; else m_age++;
            default: ;
         endcase
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      shift_q.delete(); shdir_q.delete(); clr_q.delete(); ld_q.delete();
      rep_first = -1;
   endtask

   initial begin
      int exp_off[5];
      exp_off = '{0, 4, 6, 8, 10};
      rep_first = -1;
      step(3);
      rst = 1'b0;
      step(3);
      chk("boot_sel_idle", sel_out, 2'b11);
      chk("boot_count",    cnt_out, 0);

      // Held right shift: pulses at T, T+4, T+6, T+8, T+10.
      clear_logs();
      sel_in = 2'b01; step(12);
      sel_in = 2'b00; step(3);
      chk("hold_npulses", shift_q.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < shift_q.size()) chk("hold_offset", shift_q[i] - shift_q[0], exp_off[i]);
      if (shift_q.size() > 0) chk("rep_first_offset", rep_first - shift_q[0], 4);
      chk("hold_count", cnt_out, 5);

      // Clear held 10 cycles: one pulse, count cleared.
      clear_logs();
      clr_in = 1'b0; step(10);
      clr_in = 1'b1; step(3);
      chk("clr_npulses", clr_q.size(), 1);
      chk("clr_count", cnt_out, 0);

      // Short left press: single pulse, no repeat.
      clear_logs();
      sel_in = 2'b10; step(2);
      sel_in = 2'b00; step(3);
      chk("short_npulses", shift_q.size(), 1);
      if (shdir_q.size() > 0) chk("short_dir", shdir_q[0], 2'b10);
      chk("short_count", cnt_out, 1);
      chk("short_no_rep", rep_first, -1);

      // All requests together: clear wins, then load after clear release.
      clear_logs();
      clr_in = 1'b0; ld_in = 1'b0; sel_in = 2'b01; step(3);
      clr_in = 1'b1; sel_in = 2'b00; step(3);
      ld_in = 1'b1; step(3);
      chk("prio_clr", clr_q.size(), 1);
      chk("prio_ld",  ld_q.size(), 1);
      chk("prio_no_shift", shift_q.size(), 0);
      if (clr_q.size() > 0 && ld_q.size() > 0) chk("prio_order", int'(ld_q[0] > clr_q[0]), 1);
      chk("prio_count", cnt_out, 0);

      // Reset in the middle of a shift pulse.
      sel_in = 2'b01; step(1);
      chk("pre_rst_pulse", sel_out, 2'b01);
      rst = 1'b1; #1;
      chk("rst_clr", clr_out, 1);
      chk("rst_ld",  ld_out, 1);
      chk("rst_sel", sel_out, 2'b11);
      chk("rst_cnt", cnt_out, 0);
      chk("rst_rep", rep_out, 0);
      sel_in = 2'b00;
      step(1);
      rst = 1'b0;
      step(3);

      // Long hold saturates the count, then a direction change restarts it.
      clear_logs();
      sel_in = 2'b01; step(40);
      chk("sat_count", cnt_out, CMAX);
      sel_in = 2'b10; step(4);
      sel_in = 2'b00; step(3);
      if (shdir_q.size() > 0) chk("dirchg_dir", shdir_q[shdir_q.size()-1], 2'b10);
      chk("dirchg_count", cnt_out, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
